ram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port program/data RAM (8-bit words, 32 locations, synchronous read/write, read data registered on the clock edge). Port 0 serves the processor core (fetch/load/store); port 1 serves the program loader/debug host. The block selects one requester at a time, drives the RAM's data, address and write lines, and returns read data plus a completion pulse to the winner. It sits between the core/loader and the RAM, and is the only driver of the RAM inputs.

---
 rtl/ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and access sequencer for a single-port
// synchronous RAM. Port 0 is the processor core, port 1 the loader/debug host.
// One access is serviced at a time: IDLE (grant) -> ISSUE -> RESP -> IDLE.
module ram_arbiter #(
  parameter int RAM_BITS      = 8,
  parameter int ADDR_BITS     = 5,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_p0_req,
  input  logic                 i_p0_we,
  input  logic [ADDR_BITS-1:0] i_p0_addr,
  input  logic [RAM_BITS-1:0]  i_p0_wdata,
  input  logic                 i_p1_req,
  input  logic                 i_p1_we,
  input  logic [ADDR_BITS-1:0] i_p1_addr,
  input  logic [RAM_BITS-1:0]  i_p1_wdata,
  output logic                 o_p0_gnt,
  output logic                 o_p1_gnt,
  output logic                 o_p0_done,
  output logic                 o_p1_done,
  output logic [RAM_BITS-1:0]  o_p0_rdata,
  output logic [RAM_BITS-1:0]  o_p1_rdata,
  output logic [RAM_BITS-1:0]  o_ram_data_in,
  output logic [ADDR_BITS-1:0] o_ram_addr,
  output logic                 o_ram_write,
  input  logic [RAM_BITS-1:0]  i_ram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last;
  logic                 r_owner;
  logic                 r_is_write;
  logic                 r_ram_write;
  logic [ADDR_BITS-1:0] r_ram_addr;
  logic [RAM_BITS-1:0]  r_ram_data_in;
  logic                 r_p0_done;
  logic                 r_p1_done;
  logic [RAM_BITS-1:0]  r_p0_rdata;
  logic [RAM_BITS-1:0]  r_p1_rdata;
  logic                 w_any_req;
  logic                 w_win1;
  logic                 w_grant;
  logic                 w_win_we;
  logic [ADDR_BITS-1:0] w_win_addr;
  logic [RAM_BITS-1:0]  w_win_wdata;

  // Pick the winning port; on a tie round-robin favours the port not granted last
  always_comb begin
    w_any_req = i_p0_req | i_p1_req;
    if (i_p0_req && i_p1_req) begin
      w_win1 = (PRIORITY_MODE == 0) ? ~r_last : 1'b0;
    end else begin
      w_win1 = i_p1_req;
    end
    w_grant     = (r_state == S_IDLE) && w_any_req && i_rst_n;
    w_win_we    = w_win1 ? i_p1_we    : i_p0_we;
    w_win_addr  = w_win1 ? i_p1_addr  : i_p0_addr;
    w_win_wdata = w_win1 ? i_p1_wdata : i_p0_wdata;
  end

  // State register; reset abandons any access in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a granted access always runs ISSUE then RESP
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant outputs are combinational and only ever raised in IDLE
  always_comb begin
    o_p0_gnt = w_grant & ~w_win1;
    o_p1_gnt = w_grant &  w_win1;
  end

  // Capture the winner's request into the RAM drive registers and drop the write after ISSUE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_write   <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_owner       <= 1'b0;
      r_is_write    <= 1'b0;
      r_last        <= 1'b1;
    end else begin
      if (w_grant) begin
        r_ram_write   <= w_win_we;
        r_ram_addr    <= w_win_addr;
        r_ram_data_in <= w_win_wdata;
        r_owner       <= w_win1;
        r_is_write    <= w_win_we;
        r_last        <= w_win1;
      end else if (r_state == S_ISSUE) begin
        r_ram_write   <= 1'b0;
      end
    end
  end

  // Return read data and a one-cycle completion pulse to the owning port only
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p0_done  <= 1'b0;
      r_p1_done  <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_p0_done <= 1'b0;
      r_p1_done <= 1'b0;
      if (r_state == S_RESP) begin
        if (r_owner) begin
          r_p1_done <= 1'b1;
          if (!r_is_write) r_p1_rdata <= i_ram_data_out;
        end else begin
          r_p0_done <= 1'b1;
          if (!r_is_write) r_p0_rdata <= i_ram_data_out;
        end
      end
    end
  end

  assign o_p0_done     = r_p0_done;
  assign o_p1_done     = r_p1_done;
  assign o_p0_rdata    = r_p0_rdata;
  assign o_p1_rdata    = r_p1_rdata;
  assign o_ram_write   = r_ram_write;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: two arbiter instances (instance 0 round-robin, instance 1
// fixed priority), each attached to its own behavioural synchronous RAM.
module tb_ram_arbiter;
  localparam int RB = 8;
  localparam int AB = 5;

  typedef struct {
    logic rst;
    logic r0, w0; logic [AB-1:0] a0; logic [RB-1:0] d0;
    logic r1, w1; logic [AB-1:0] a1; logic [RB-1:0] d1;
    logic g0, g1, dn0, dn1, wr;
    logic [RB-1:0] rd0, rd1;
  } vec_t;

  logic          clk;
  logic          rstN [2];
  logic          req [2][2];
  logic          we [2][2];
  logic [AB-1:0] addr [2][2];
  logic [RB-1:0] wdata [2][2];
  logic          gnt [2][2];
  logic          done [2][2];
  logic [RB-1:0] rdata [2][2];
  logic [RB-1:0] ramDin [2];
  logic [AB-1:0] ramAddr [2];
  logic          ramWrite [2];
  logic          preEn [2];
  logic [AB-1:0] preAddr [2];
  logic [RB-1:0] preData [2];

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  // Reference model state for the randomized phase
  int            cd [2];
  int            owner [2];
  int            ownerWe [2];
  int            lastG [2];
  logic [RB-1:0] pend [2];
  logic [RB-1:0] expR [2][2];
  logic          granted [2][2];
  logic [RB-1:0] mm [2][32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gInst
    logic [RB-1:0] mem [32];
    logic [RB-1:0] ramDout;

    ram_arbiter #(.RAM_BITS(RB), .ADDR_BITS(AB), .PRIORITY_MODE(g)) dut (
      .i_clk(clk), .i_rst_n(rstN[g]),
      .i_p0_req(req[g][0]), .i_p0_we(we[g][0]), .i_p0_addr(addr[g][0]), .i_p0_wdata(wdata[g][0]),
      .i_p1_req(req[g][1]), .i_p1_we(we[g][1]), .i_p1_addr(addr[g][1]), .i_p1_wdata(wdata[g][1]),
      .o_p0_gnt(gnt[g][0]), .o_p1_gnt(gnt[g][1]),
      .o_p0_done(done[g][0]), .o_p1_done(done[g][1]),
      .o_p0_rdata(rdata[g][0]), .o_p1_rdata(rdata[g][1]),
      .o_ram_data_in(ramDin[g]), .o_ram_addr(ramAddr[g]), .o_ram_write(ramWrite[g]),
      .i_ram_data_out(ramDout)
    );

    // Single-port synchronous RAM with registered read data and a bench preload path
    always @(posedge clk) begin
      if (preEn[g]) mem[preAddr[g]] <= preData[g];
      else if (ramWrite[g]) mem[ramAddr[g]] <= ramDin[g];
      ramDout <= mem[ramAddr[g]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic rst, input logic r0, input logic w0, input int a0, input int d0,
                                 input logic r1, input logic w1, input int a1, input int d1,
                                 input logic g0, input logic g1, input logic dn0, input logic dn1,
                                 input logic wr, input int rd0, input int rd1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0[AB-1:0]; v.d0 = d0[RB-1:0];
    v.r1 = r1; v.w1 = w1; v.a1 = a1[AB-1:0]; v.d1 = d1[RB-1:0];
    v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1; v.wr = wr;
    v.rd0 = rd0[RB-1:0]; v.rd1 = rd1[RB-1:0];
    return v;
  endfunction

  // Drive one table row onto instance 0 at the falling edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rstN[0] = v.rst;
    req[0][0] = v.r0; we[0][0] = v.w0; addr[0][0] = v.a0; wdata[0][0] = v.d0;
    req[0][1] = v.r1; we[0][1] = v.w1; addr[0][1] = v.a1; wdata[0][1] = v.d1;
  endtask

  task automatic preload(input int a, input logic [RB-1:0] d0, input logic [RB-1:0] d1);
    @(negedge clk);
    preEn[0] = 1'b1; preAddr[0] = a[AB-1:0]; preData[0] = d0;
    preEn[1] = 1'b1; preAddr[1] = a[AB-1:0]; preData[1] = d1;
    @(negedge clk);
    preEn[0] = 1'b0; preEn[1] = 1'b0;
  endtask

  task automatic clearInputs(input int i);
    for (int p = 0; p < 2; p++) begin
      req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
    end
  endtask

  initial begin
    rstN[0] = 1'b0; rstN[1] = 1'b0;
    preEn[0] = 1'b0; preEn[1] = 1'b0;
    preAddr[0] = '0; preAddr[1] = '0; preData[0] = '0; preData[1] = '0;
    clearInputs(0); clearInputs(1);

    preload(0, 8'h80, 8'h80);
    preload(31, 8'h00, 8'hC3);

    // ---------------- Table-driven cycle vectors, instance 0 (round-robin)
    //                   rst r0 w0 a0 d0  r1 w1 a1 d1     g0 g1 dn0 dn1 wr rd0   rd1
    vecs.push_back(mkVec(0, 1, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0,    0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   0, 0, 0, 0,     1, 0, 0, 0, 0, 0,    0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0,    0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0,    0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   1, 1, 30, 'h5A, 0, 1, 1, 0, 0, 'h80, 0));
    vecs.push_back(mkVec(1, 1, 0, 30, 0,  0, 0, 0, 0,     0, 0, 0, 0, 1, 'h80, 0));
    vecs.push_back(mkVec(1, 1, 0, 30, 0,  0, 0, 0, 0,     0, 0, 0, 0, 0, 'h80, 0));
    vecs.push_back(mkVec(1, 1, 0, 30, 0,  0, 0, 0, 0,     1, 0, 0, 1, 0, 'h80, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 'h80, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 'h80, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 1, 1, 0, 0, 'h5A, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 0, 0, 0, 0, 'h5A, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 0, 0, 0, 0, 'h5A, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    1, 0, 0, 1, 0, 'h5A, 'h5A));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 0, 0, 0, 0, 'h5A, 'h5A));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 0, 0, 0, 0, 'h5A, 'h5A));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 1, 1, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 0, 0, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   1, 0, 30, 0,    0, 0, 0, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 1, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 1, 0, 0, 0,   0, 0, 0, 0,     1, 0, 0, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   1, 1, 0, 'h33,  0, 0, 0, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   1, 1, 0, 'h33,  0, 0, 0, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 1, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 'h80, 'h5A));
    vecs.push_back(mkVec(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 'h80, 'h5A));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("vec%0d p0_gnt", k), 32'(gnt[0][0]), 32'(vecs[k].g0));
      checkOutput($sformatf("vec%0d p1_gnt", k), 32'(gnt[0][1]), 32'(vecs[k].g1));
      checkOutput($sformatf("vec%0d p0_done", k), 32'(done[0][0]), 32'(vecs[k].dn0));
      checkOutput($sformatf("vec%0d p1_done", k), 32'(done[0][1]), 32'(vecs[k].dn1));
      checkOutput($sformatf("vec%0d ram_write", k), 32'(ramWrite[0]), 32'(vecs[k].wr));
      checkOutput($sformatf("vec%0d p0_rdata", k), 32'(rdata[0][0]), 32'(vecs[k].rd0));
      checkOutput($sformatf("vec%0d p1_rdata", k), 32'(rdata[0][1]), 32'(vecs[k].rd1));
    end
    checkOutput("dropped write left RAM[0]", 32'(gInst[0].mem[0]), 32'h80);

    // ---------------- Fixed priority, instance 1: port 0 held starves port 1
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rstN[1] = 1'b1;
      req[1][0] = (c < 12); we[1][0] = 1'b0; addr[1][0] = 5'd0;
      req[1][1] = (c < 13); we[1][1] = 1'b0; addr[1][1] = 5'd31;
      #1;
      checkOutput($sformatf("prio c%0d p0_gnt", c), 32'(gnt[1][0]), 32'(c < 12 && c % 3 == 0));
      checkOutput($sformatf("prio c%0d p1_gnt", c), 32'(gnt[1][1]), 32'(c == 12));
      checkOutput($sformatf("prio c%0d p0_done", c), 32'(done[1][0]), 32'(c > 0 && c % 3 == 0 && c <= 12));
      checkOutput($sformatf("prio c%0d p1_done", c), 32'(done[1][1]), 32'(c == 15));
      checkOutput($sformatf("prio c%0d p0_rdata", c), 32'(rdata[1][0]), (c >= 3) ? 32'h80 : 32'h0);
      checkOutput($sformatf("prio c%0d p1_rdata", c), 32'(rdata[1][1]), (c == 15) ? 32'hC3 : 32'h0);
    end

    // ---------------- Reset during ISSUE of a write suppresses it
    @(negedge clk);
    req[1][1] = 1'b1; we[1][1] = 1'b1; addr[1][1] = 5'd31; wdata[1][1] = 8'hFF;
    #1;
    checkOutput("midrst write gnt", 32'(gnt[1][1]), 32'd1);
    @(negedge clk);
    req[1][1] = 1'b0; we[1][1] = 1'b0;
    rstN[1] = 1'b0;
    #1;
    checkOutput("midrst ram_write", 32'(ramWrite[1]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 5'd31;
      #1;
      checkOutput($sformatf("inrst c%0d p0_gnt", c), 32'(gnt[1][0]), 32'd0);
      checkOutput($sformatf("inrst c%0d done", c), 32'({done[1][0], done[1][1]}), 32'd0);
      checkOutput($sformatf("inrst c%0d ram_write", c), 32'(ramWrite[1]), 32'd0);
      checkOutput($sformatf("inrst c%0d rdata", c), 32'({rdata[1][0], rdata[1][1]}), 32'd0);
    end
    checkOutput("midrst RAM[31] kept", 32'(gInst[1].mem[31]), 32'hC3);
    @(negedge clk);
    rstN[1] = 1'b1;
    #1;
    checkOutput("post-reset p0_gnt", 32'(gnt[1][0]), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req[1][0] = 1'b0;
      #1;
      checkOutput($sformatf("post-reset +%0d p0_done", c), 32'(done[1][0]), 32'(c == 3));
      checkOutput($sformatf("post-reset +%0d p1_done", c), 32'(done[1][1]), 32'd0);
    end
    checkOutput("post-reset p0_rdata", 32'(rdata[1][0]), 32'hC3);

    // ---------------- Randomized traffic on both instances against a transaction model
    @(negedge clk);
    rstN[0] = 1'b0; rstN[1] = 1'b0;
    clearInputs(0); clearInputs(1);
    for (int a = 0; a < 32; a++) begin
      mm[0][a] = 8'($urandom);
      mm[1][a] = 8'($urandom);
      preload(a, mm[0][a], mm[1][a]);
    end
    for (int i = 0; i < 2; i++) begin
      cd[i] = -1; owner[i] = 0; ownerWe[i] = 0; lastG[i] = 1; pend[i] = '0;
      for (int p = 0; p < 2; p++) begin
        expR[i][p] = '0; granted[i][p] = 1'b0;
      end
    end
    @(negedge clk);
    rstN[0] = 1'b1; rstN[1] = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (req[i][p] && granted[i][p]) req[i][p] = 1'b0;
          else if (req[i][p] && ($urandom % 16 == 0)) req[i][p] = 1'b0;
          granted[i][p] = 1'b0;
          if (!req[i][p] && ($urandom % 3 == 0)) begin
            req[i][p]   = 1'b1;
            we[i][p]    = 1'($urandom % 2);
            addr[i][p]  = 5'($urandom_range(0, 7));
            wdata[i][p] = 8'($urandom);
          end
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        int win;
        win = -1;
        if (cd[i] <= 0) begin
          if (req[i][0] && req[i][1]) win = (i == 1) ? 0 : ((lastG[i] == 0) ? 1 : 0);
          else if (req[i][0]) win = 0;
          else if (req[i][1]) win = 1;
        end
        if (cd[i] == 0 && ownerWe[i] == 0) expR[i][owner[i]] = pend[i];
        for (int p = 0; p < 2; p++) begin
          checkOutput($sformatf("rand i%0d c%0d gnt%0d", i, cyc, p), 32'(gnt[i][p]), 32'(win == p));
          checkOutput($sformatf("rand i%0d c%0d done%0d", i, cyc, p), 32'(done[i][p]),
                      32'(cd[i] == 0 && owner[i] == p));
          checkOutput($sformatf("rand i%0d c%0d rdata%0d", i, cyc, p), 32'(rdata[i][p]), 32'(expR[i][p]));
        end
        checkOutput($sformatf("rand i%0d c%0d ram_write", i, cyc), 32'(ramWrite[i]),
                    32'(cd[i] == 2 && ownerWe[i] == 1));
        if (win >= 0) begin
          owner[i]   = win;
          ownerWe[i] = int'(we[i][win]);
          pend[i]    = mm[i][addr[i][win]];
          if (we[i][win]) mm[i][addr[i][win]] = wdata[i][win];
          lastG[i]   = win;
          cd[i]      = 3;
          granted[i][win] = 1'b1;
        end
        if (cd[i] >= 0) cd[i]--;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
